// File: rtl/evm_ballot_ctrl.sv
// Electronic voting machine ballot controller: officer-armed single-vote capture,
// saturating per-candidate tallies, and a sequential winner/tie scan after close.
module evm_ballot_ctrl #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  localparam int IDX_W   = $clog2(NUM_CAND),
  localparam int TOT_W   = CNT_W + IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic                      close,
  input  logic [NUM_CAND-1:0]       vswitch,
  output logic [NUM_CAND*CNT_W-1:0] counts,
  output logic [TOT_W-1:0]          total,
  output logic                      ready,
  output logic                      vote_ack,
  output logic                      inv,
  output logic                      sat_err,
  output logic                      closed,
  output logic                      result_valid,
  output logic [IDX_W-1:0]          winner,
  output logic                      tie
);

  typedef enum logic [2:0] {IDLE, ARMED, WAIT_REL, TALLY, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W:0]   SCAN_END = (IDX_W+1)'(NUM_CAND);

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg [NUM_CAND];
  logic [NUM_CAND-1:0]   full_vec;
  logic                  press, one_hot, sel_full;
  logic                  vote_accept, inv_next, sat_set;
  logic                  scan_start, scan_step, scan_done;
  logic [IDX_W:0]        scan_idx_reg;
  logic [CNT_W-1:0]      best_reg, scan_cnt;
  logic [IDX_W-1:0]      scan_win_reg;
  logic                  scan_tie_reg;

  assign press    = |vswitch;
  assign one_hot  = press && ((vswitch & (vswitch - NUM_CAND'(1))) == '0);
  assign sel_full = |full_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CAND; gi++) begin : g_cand
      assign counts[gi*CNT_W +: CNT_W] = cnt_reg[gi];
      assign full_vec[gi] = vswitch[gi] && (cnt_reg[gi] == CNT_MAX);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    vote_accept = 1'b0;
    inv_next    = 1'b0;
    sat_set     = 1'b0;
    scan_start  = 1'b0;
    scan_step   = 1'b0;
    scan_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        // close takes priority over a simultaneous arm
        if (close) begin
          state_next = TALLY;
          scan_start = 1'b1;
        end else if (arm && !press) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (press) begin
          if (!one_hot) begin
            inv_next = 1'b1;
          end else if (sel_full) begin
            inv_next = 1'b1;
            sat_set  = 1'b1;
          end else begin
            vote_accept = 1'b1;
            state_next  = WAIT_REL;
          end
        end
      end
      WAIT_REL: begin
        if (!press) state_next = IDLE;
      end
      TALLY: begin
        if (scan_idx_reg < SCAN_END) begin
          scan_step = 1'b1;
        end else begin
          scan_done  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CAND; i++) cnt_reg[i] <= '0;
    end else if (vote_accept) begin
      for (int i = 0; i < NUM_CAND; i++)
        if (vswitch[i]) cnt_reg[i] <= cnt_reg[i] + CNT_W'(1);
    end
  end

  always_comb begin
    scan_cnt = '0;
    for (int i = 0; i < NUM_CAND; i++)
      if (scan_idx_reg == (IDX_W+1)'(i)) scan_cnt = cnt_reg[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total        <= '0;
      ready        <= 1'b0;
      vote_ack     <= 1'b0;
      inv          <= 1'b0;
      sat_err      <= 1'b0;
      closed       <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      if (vote_accept) total <= total + TOT_W'(1);
      ready        <= (state_next == ARMED);
      vote_ack     <= vote_accept;
      inv          <= inv_next;
      sat_err      <= sat_err | sat_set;
      closed       <= (state_next == TALLY) || (state_next == DONE);
      result_valid <= (state_next == DONE);
    end
  end

  // Scan works in private registers; winner/tie only change when DONE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx_reg <= '0;
      best_reg     <= '0;
      scan_win_reg <= '0;
      scan_tie_reg <= 1'b0;
      winner       <= '0;
      tie          <= 1'b0;
    end else begin
      if (scan_start) begin
        best_reg     <= cnt_reg[0];
        scan_win_reg <= '0;
        scan_tie_reg <= 1'b0;
        scan_idx_reg <= (IDX_W+1)'(1);
      end
      if (scan_step) begin
        if (scan_cnt > best_reg) begin
          best_reg     <= scan_cnt;
          scan_win_reg <= scan_idx_reg[IDX_W-1:0];
          scan_tie_reg <= 1'b0;
        end else if (scan_cnt == best_reg) begin
          scan_tie_reg <= 1'b1;
        end
        scan_idx_reg <= scan_idx_reg + (IDX_W+1)'(1);
      end
      if (scan_done) begin
        winner <= scan_win_reg;
        tie    <= scan_tie_reg;
      end
    end
  end

endmodule
